pc_unit: RTL

- Program-counter and next-PC stage of the single-cycle RV32 core.
- Consumes the ALU's zero_flag, sign_flag and result to resolve conditional branches, JAL and JALR.
- Holds the architectural PC register and supplies pc and pc_plus4 to instruction fetch and writeback.
- Detects misaligned control-transfer targets, redirects to a trap vector, and keeps a retired-instruction counter.

---
 rtl/pc_unit.sv | 65 ++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: RV32 program counter, next-PC select, misalignment trap and retire counter
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic branch,
  input  logic [2:0] branch_type,
  input  logic jump,
  input  logic jalr,
  input  logic [WIDTH-1:0] imm,
  input  logic zero_flag,
  input  logic sign_flag,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic taken,
  output logic fetch_valid,
  output logic trap,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] retired
);
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t state, state_nx;
  logic cond, misaligned, advance;
  logic [WIDTH-1:0] target, next_pc;
  assign pc_plus4 = pc + WIDTH'(4);
  always_comb begin
    cond = branch_type == 3'b000 ? zero_flag :
           branch_type == 3'b001 ? !zero_flag :
           branch_type == 3'b100 ? sign_flag :
           branch_type == 3'b101 ? !sign_flag : 1'b0;
    taken = jalr | jump | (branch & cond);
    target = jalr ? alu_result & ~WIDTH'(1) : pc + imm;
    next_pc = taken ? target : pc_plus4;
    misaligned = state == RUN && !stall && taken && target[1:0] != 2'b00;
    advance = state == RUN && !stall && !misaligned;
    state_nx = misaligned ? TRAP : RUN;
  end
  always_ff @(posedge clk)
    if (rst) state <= BOOT;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      trap <= 1'b0;
      epc <= '0;
      retired <= '0;
    end else begin
      fetch_valid <= 1'b1;
      trap <= misaligned;
      if (misaligned) begin
        epc <= pc;
        pc <= TRAP_VECTOR;
      end else if (advance) begin
        pc <= next_pc;
        retired <= retired + WIDTH'(1);
      end
    end
  end
endmodule
